sysarray_mm_param: RTL and testbench
====================================

// Module: sysarray_mm_param
// PURPOSE
//  Parametrised NxN output-stationary systolic matrix multiplier, C = A*B, signed.
//  Next generation of the fixed 3x3 sysarr array. Adds:
//  - internal operand skewing;
//  - a valid/ready streaming input of K beats, with any K >= 1;
//  - a FLUSH phase;
//  - row-by-row drain of C with backpressure.
//  Sits between operand buffers and the result sink of the matrix datapath.
// PARAMETERS
//  N   3   array dimension: N x N PEs, and the A row count and B column count
//  DW  8   operand width, signed two's complement
//  AW  32  accumulator and result width, signed; must satisfy AW >= 2*DW
// PORTS
//  clock      in   1     rising-edge clock
//  reset      in   1     synchronous, active-high reset
//  in_valid   in   1     a_col/b_row/in_last valid
//  in_ready   out  1     block accepts a beat
//  a_col      in   N*DW  column k of A; a_col[i*DW +: DW] = A[i][k]
//  b_row      in   N*DW  row k of B; b_row[j*DW +: DW] = B[k][j]
//  in_last    in   1     beat is the final k of this product
//  out_valid  out  1     out_row valid
//  out_ready  in   1     sink accepts out_row
//  out_row    out  N*AW  row r of C; out_row[j*AW +: AW] = C[r][j]
//  out_last   out  1     out_row is row N-1
//  busy       out  1     high in LOAD, FLUSH or DRAIN
// BEHAVIOUR
//  Reset (synchronous, priority over all else):
//   - state=IDLE; skew lines, PE operand regs, accumulators, beat/row counters = 0.
//   - While reset is high: in_ready=0, out_valid=0, out_last=0, busy=0, out_row=0.
//  Beat acceptance: a beat is taken on an edge with in_valid && in_ready.
//  FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
//   IDLE:
//    - in_ready=1.
//    - First accepted beat clears every accumulator in the same cycle as its injection.
//    - Go to LOAD, or straight to FLUSH if that beat has in_last.
//   LOAD:
//    - in_ready=1.
//    - If in_valid=0, zeros are injected into the skew lines (bubble); the result is unaffected.
//    - The beat with in_last -> FLUSH.
//   FLUSH:
//    - in_ready=0.
//    - Counter runs for exactly 2N-1 cycles: skew N-1, propagation N-1, MAC 1.
//    - Zeros are injected during FLUSH. Then -> DRAIN.
//   DRAIN:
//    - in_ready=0, out_valid=1, out_row = C[r] for r = 0..N-1.
//    - r advances only on out_valid && out_ready; out_row is held stable while out_ready=0.
//    - out_last=1 when r=N-1; that handshake -> IDLE.
//  Skew: row i of A is delayed i cycles; column j of B is delayed j cycles.
//  PE[i][j] each cycle:
//   - acc += sext(a)*sext(b); product is full 2*DW bits, sign-extended to AW.
//   - Passes a right and b down through registers.
//  Overflow: accumulators wrap modulo 2^AW; no saturation and no flag.
//  Latency: out_valid first high 2N edges after the edge that accepts in_last.
//  Accumulators are frozen in DRAIN. C stays readable until the next IDLE beat.
//  Reset mid-LOAD, FLUSH or DRAIN:
//   - The partial product is discarded; no out_valid follows.
//   - The next product starts clean.
//  A beat offered in FLUSH or DRAIN is not accepted; in_ready=0 there.
// TESTING
//  T1 N=3, DW=8:
//   - A=B=[1..9] row-major, 3 beats back-to-back, out_ready=1.
//   - Rows are [30,36,42], [66,81,96], [102,126,150].
//   - out_valid rises 6 edges after in_last; out_last on row 2.
//  T2 signed: A=-I (3x3), B=[1..9].
//   - Rows are [-1,-2,-3], [-4,-5,-6], [-7,-8,-9] as 32-bit two's complement.
//  T3 bubbles/backpressure: T1 data with in_valid low 2 cycles between beats, out_ready toggling 0/1.
//   - Same C as T1.
//   - out_row is held while out_ready=0; exactly 3 handshakes occur.
//  T4 reset in LOAD after beat 1, then clean T1.
//   - No out_valid before the restart.
//   - Result equals T1; no residue from the aborted beat.
//  T5 N=4, AW=16: A=all 127, B=all 127, K=4.
//   - Each entry is 64516 mod 2^16 = -1020 (0xFC04), showing wrap.
//  T6 K=1: single beat with in_last, A col=[1,2,3], B row=[4,5,6].
//   - C = outer product: [4,5,6], [8,10,12], [12,15,18]; FSM goes IDLE -> FLUSH directly.

Source files
------------

// File: rtl/sysarray_mm_param.sv
// Parametrised NxN output-stationary systolic matrix multiplier, C = A*B (signed).
// Operands stream in as K column/row beats, are skewed internally, accumulate in
// a PE grid, then C is drained one row per handshake with backpressure.
module sysarray_mm_param #(
  parameter int N  = 3,
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] a_col,
  input  logic [N*DW-1:0] b_row,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_row,
  output logic            out_last,
  output logic            busy
);

  localparam int FCW = $clog2(2 * N) + 1;
  localparam int RW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [FCW-1:0] FLUSH_END = FCW'(2 * N - 1);
  localparam logic [RW-1:0]  ROW_END   = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t         state, state_n;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [RW-1:0]  row, row_n;
  logic           accept;
  logic           clr;
  logic           mac_en;

  // skew lines: stage 0 is the injection register, row/column i is tapped at stage i
  logic signed [DW-1:0]   ska  [N][N];
  logic signed [DW-1:0]   skb  [N][N];
  // PE operand registers, accumulators and products
  logic signed [DW-1:0]   pa   [N][N];
  logic signed [DW-1:0]   pb   [N][N];
  logic signed [AW-1:0]   acc  [N][N];
  logic signed [2*DW-1:0] prod [N][N];

  assign accept = in_valid && in_ready;

  // state, flush counter and drain row register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      fcnt  <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      fcnt  <= fcnt_n;
      row   <= row_n;
    end
  end

  // next-state logic and handshake/status outputs
  // Flush count 0 is the cycle the last beat sits in the injection register;
  // counts 1..2N-1 cover skew, propagation and the final MAC.
  always_comb begin
    state_n   = state;
    fcnt_n    = fcnt;
    row_n     = row;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    clr       = 1'b0;
    mac_en    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          clr     = 1'b1;
          fcnt_n  = '0;
          state_n = in_last ? FLUSH : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        mac_en   = 1'b1;
        if (in_valid && in_last) begin
          state_n = FLUSH;
          fcnt_n  = '0;
        end
      end
      FLUSH: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (fcnt == FLUSH_END) begin
          state_n = DRAIN;
          fcnt_n  = '0;
          row_n   = '0;
        end else begin
          fcnt_n = fcnt + FCW'(1);
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (row == ROW_END);
        if (out_ready) begin
          if (row == ROW_END) begin
            state_n = IDLE;
            row_n   = '0;
          end else begin
            row_n = row + RW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      busy      = 1'b0;
      clr       = 1'b0;
    end
  end

  // operand injection (zeros when no beat is taken) and skew delay lines
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned d = 0; d < N; d++) begin
          ska[i][d] <= '0;
          skb[i][d] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        ska[i][0] <= accept ? a_col[i*DW +: DW] : '0;
        skb[i][0] <= accept ? b_row[i*DW +: DW] : '0;
        for (int unsigned d = 1; d < N; d++) begin
          ska[i][d] <= ska[i][d-1];
          skb[i][d] <= skb[i][d-1];
        end
      end
    end
  end

  // full-width signed product of each PE's operand pair
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        prod[i][j] = pa[i][j] * pb[i][j];
      end
    end
  end

  // PE grid: pass a right and b down, accumulate modulo 2^AW
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        pa[i][0] <= ska[i][i];
        pb[0][i] <= skb[i][i];
        for (int unsigned j = 1; j < N; j++) begin
          pa[i][j] <= pa[i][j-1];
          pb[j][i] <= pb[j-1][i];
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (clr) begin
            acc[i][j] <= '0;
          end else if (mac_en) begin
            acc[i][j] <= acc[i][j] + AW'(prod[i][j]);
          end
        end
      end
    end
  end

  // present the selected row of C while draining
  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int unsigned j = 0; j < N; j++) begin
        out_row[j*AW +: AW] = acc[row][j];
      end
    end
  end

endmodule

// File: tb/tb_sysarray_mm_param.sv
// Directed bench for sysarray_mm_param: 3x3/32-bit instance for products, signed,
// bubbles, backpressure, abort and K=1; 4x4/16-bit instance for accumulator wrap.
module tb_sysarray_mm_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_last, busy;
  logic [23:0] a_col, b_row;
  logic [95:0] out_row;

  logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, out_last4, busy4;
  logic [31:0] a_col4, b_row4;
  logic [63:0] out_row4;

  sysarray_mm_param #(.N(3), .DW(8), .AW(32)) dut3 (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  sysarray_mm_param #(.N(4), .DW(8), .AW(16)) dut4 (
    .clock(clk), .reset(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a_col(a_col4), .b_row(b_row4), .in_last(in_last4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_row(out_row4), .out_last(out_last4), .busy(busy4)
  );

  int total = 0;
  int bad   = 0;
  int ma [3][3];
  int mb [3][3];
  logic [95:0] q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] row3(input int r, input int kk);
    logic [95:0] v;
    int s;
    v = '0;
    for (int j = 0; j < 3; j++) begin
      s = 0;
      for (int k = 0; k < kk; k++) s += ma[r][k] * mb[k][j];
      v[j*32 +: 32] = s;
    end
    return v;
  endfunction

  task automatic pack3(input int k);
    for (int i = 0; i < 3; i++) begin
      a_col[i*8 +: 8] = ma[i][k][7:0];
      b_row[i*8 +: 8] = mb[k][i][7:0];
    end
  endtask

  task automatic set_seq();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j] = 3 * i + j + 1;
        mb[i][j] = 3 * i + j + 1;
      end
  endtask

  task automatic load3(input int kk, input int gap);
    for (int r = 0; r < 3; r++) q.push_back(row3(r, kk));
    for (int k = 0; k < kk; k++) begin
      in_valid = 1'b1;
      in_last  = (k == kk - 1);
      pack3(k);
      chk("rdy_load", 128'(in_ready), 128'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k < kk - 1) begin
        for (int g = 0; g < gap; g++) begin
          a_col = '1;
          b_row = '1;
          tick();
        end
      end
    end
    chk("rdy_flush", 128'(in_ready), 128'd0);
    chk("busy_flush", 128'(busy), 128'd1);
    // a beat offered during FLUSH must be ignored
    in_valid = 1'b1;
    in_last  = 1'b1;
    a_col    = '1;
    b_row    = '1;
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency", 128'(lat), 128'(exp_lat));
  endtask

  task automatic drain3(input bit bp);
    int hs, cyc;
    bit held;
    logic [95:0] prev, exp;
    hs = 0;
    cyc = 0;
    held = 1'b0;
    prev = '0;
    chk("rdy_drain", 128'(in_ready), 128'd0);
    while (hs < 3 && cyc < 60) begin
      out_ready = bp ? cyc[0] : 1'b1;
      if (held) chk("hold", 128'(out_row), 128'(prev));
      held = out_valid && !out_ready;
      prev = out_row;
      if (out_valid && out_ready) begin
        if (q.size() > 0) exp = q.pop_front();
        else exp = 'x;
        chk("row", 128'(out_row), 128'(exp));
        chk("last", 128'(out_last), 128'(hs == 2));
        hs++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk("handshakes", 128'(hs), 128'd3);
    chk("idle_valid", 128'(out_valid), 128'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("idle_ready", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int nov, lat, hs;
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_last4 = 1'b0; a_col4 = '0; b_row4 = '0; out_ready4 = 1'b1;
    tick();
    tick();
    chk("rst_ready", 128'(in_ready), 128'd0);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_last", 128'(out_last), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_row", 128'(out_row), 128'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 128'(in_ready), 128'd1);
    chk("post_rst_busy", 128'(busy), 128'd0);

    // T1: A = B = [1..9]
    set_seq();
    load3(3, 0);
    wait_out(6);
    drain3(1'b0);

    // T2: A = -I
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) ma[i][j] = (i == j) ? -1 : 0;
    load3(3, 0);
    wait_out(6);
    drain3(1'b0);

    // T3: bubbles between beats, toggling out_ready
    set_seq();
    load3(3, 2);
    wait_out(6);
    drain3(1'b1);

    // T4: reset after the first beat, then a clean product
    in_valid = 1'b1;
    in_last  = 1'b0;
    ma[0][0] = 100; ma[1][0] = 100; ma[2][0] = 100;
    mb[0][0] = 100; mb[0][1] = 100; mb[0][2] = 100;
    pack3(0);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("abort_rst_ready", 128'(in_ready), 128'd0);
    chk("abort_rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    nov = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) nov++;
    end
    chk("abort_no_valid", 128'(nov), 128'd0);
    set_seq();
    load3(3, 0);
    wait_out(6);
    drain3(1'b0);

    // T6: K = 1 outer product, IDLE goes straight to FLUSH
    for (int i = 0; i < 3; i++) begin
      ma[i][0] = i + 1;
      mb[0][i] = i + 4;
    end
    load3(1, 0);
    wait_out(6);
    drain3(1'b0);

    // T5: 4x4, all 127, 16-bit accumulators wrap
    chk("t5_ready", 128'(in_ready4), 128'd1);
    for (int k = 0; k < 4; k++) begin
      in_valid4 = 1'b1;
      in_last4  = (k == 3);
      a_col4    = {4{8'h7f}};
      b_row4    = {4{8'h7f}};
      tick();
    end
    in_valid4 = 1'b0;
    in_last4  = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      tick();
      lat++;
    end
    chk("t5_latency", 128'(lat), 128'd8);
    hs = 0;
    for (int c = 0; c < 20 && hs < 4; c++) begin
      if (out_valid4 && out_ready4) begin
        chk("t5_row", 128'(out_row4), 128'({4{16'hfc04}}));
        chk("t5_last", 128'(out_last4), 128'(hs == 3));
        hs++;
      end
      tick();
    end
    chk("t5_handshakes", 128'(hs), 128'd4);
    chk("t5_idle_busy", 128'(busy4), 128'd0);

    chk("sb_empty", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
